// File: rtl/and_or_reg.sv
// -----------------------------------------------------------------------------
// and_or_reg
//   Registered bitwise AND-OR cell: Y = (A & B) | C, captured on the rising
//   edge of clk whenever in_valid qualifies the operands. A & B forms an
//   enable term and C an override term that forces the matching Y bit high.
//   The default WIDTH=1 instance is the classic three-input and-or gate with
//   a one-cycle registered output.
//
// Parameters
//   WIDTH      bit width of A, B, C and Y (legal range 1..64)
//
// Ports
//   clk        in   1      system clock, all state updates on rising edge
//   rst        in   1      synchronous reset, active-high, wins over in_valid
//   A          in   WIDTH  AND operand 1
//   B          in   WIDTH  AND operand 2
//   C          in   WIDTH  OR operand, forces corresponding Y bit high
//   in_valid   in   1      qualifies A/B/C for capture this cycle
//   Y          out  WIDTH  registered result (A & B) | C, holds when idle
//   out_valid  out  1      high for exactly the cycle after an accepted input
// -----------------------------------------------------------------------------
module and_or_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Y,
  output logic             out_valid
);

  // Bitwise and-or; every bit is independent of its neighbours.
  function automatic logic [WIDTH-1:0] and_or_f(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] c
  );
    return (a & b) | c;
  endfunction

  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_d;
  logic             out_valid_q;
  logic             out_valid_d;

  // Next-state selection: operands are only looked at when in_valid is high,
  // so unknown values on A/B/C during idle cycles never reach y_q.
  always_comb begin
    y_d         = y_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      y_d         = and_or_f(A, B, C);
      out_valid_d = 1'b1;
    end else begin
      y_d         = y_q;
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset drops a coincident in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q         <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Outputs come straight from flops: no combinational input-to-output path.
  assign Y         = y_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_and_or_reg.sv
// -----------------------------------------------------------------------------
// tb_and_or_reg
//   Self-checking bench for and_or_reg. Two instances share the controls:
//   an 8-bit one and a default 1-bit one fed with bit 0 of the operands.
//   A reference process computes the expected outputs from the sampled
//   inputs each clock and queues them; a monitor on the falling edge pops
//   and compares. Directed steps add fixed-value checks from the test plan.
// -----------------------------------------------------------------------------
module tb_and_or_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] y8;
  logic         ov8;
  logic         y1;
  logic         ov1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] y;
    logic         v;
  } exp_t;

  exp_t exp_q[$];

  and_or_reg #(.WIDTH(W)) dut8 (
    .clk(clk), .rst(rst), .A(a), .B(b), .C(c),
    .in_valid(in_valid), .Y(y8), .out_valid(ov8)
  );

  and_or_reg dut1 (
    .clk(clk), .rst(rst), .A(a[0]), .B(b[0]), .C(c[0]),
    .in_valid(in_valid), .Y(y1), .out_valid(ov1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: state is just "last accepted result"; it starts only
  // once a reset has been seen, since outputs are undefined before that.
  logic [W-1:0] model_y = '0;
  bit           armed = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    if (rst) armed = 1'b1;
    if (armed) begin
      if (rst) begin
        model_y = '0;
        e.v     = 1'b0;
      end else if (in_valid) begin
        model_y = (a & b) | c;
        e.v     = 1'b1;
      end else begin
        e.v     = 1'b0;
      end
      e.y = model_y;
      exp_q.push_back(e);
    end
  end

  // Monitor: outputs are presented every cycle, compare on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("y8_model",  y8,        e.y);
      check("ov8_model", {7'd0, ov8}, {7'd0, e.v});
      check("y1_model",  {7'd0, y1},  {7'd0, e.y[0]});
      check("ov1_model", {7'd0, ov1}, {7'd0, e.v});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v,
                       input logic [W-1:0] ai, input logic [W-1:0] bi, input logic [W-1:0] ci);
    rst = r; in_valid = v; a = ai; b = bi; c = ci;
  endtask

  logic [2:0] abc;

  initial begin
    // Reset for two cycles with all inputs high and in_valid asserted.
    #1;
    drive(1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_y",  y8, 8'h00);
      check("rst_ov", {7'd0, ov8}, 8'h00);
    end
    drive(1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    step();
    check("post_rst_y",  y8, 8'hFF);
    check("post_rst_ov", {7'd0, ov8}, 8'h01);
    check("post_rst_y1", {7'd0, y1}, 8'h01);

    // Exhaustive truth table, back-to-back, operands replicated on all bits.
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      drive(1'b0, 1'b1, {W{abc[2]}}, {W{abc[1]}}, {W{abc[0]}});
      step();
      check("tt_y1",  {7'd0, y1}, {7'd0, ((i == 1) || (i == 3) || (i >= 5)) ? 1'b1 : 1'b0});
      check("tt_ov1", {7'd0, ov1}, 8'h01);
    end

    // Hold: capture 1 then idle three cycles with zero operands.
    drive(1'b0, 1'b1, 8'hFF, 8'hFF, 8'h00);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_y",  y8, 8'hFF);
      check("hold_ov", {7'd0, ov8}, 8'h00);
    end

    // Wide bitwise pattern.
    drive(1'b0, 1'b1, 8'hF0, 8'hCC, 8'h03);
    step();
    check("wide_y",  y8, 8'hC3);
    check("wide_ov", {7'd0, ov8}, 8'h01);

    // Reset priority over a coincident in_valid.
    drive(1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    step();
    check("prio_cap", y8, 8'hFF);
    drive(1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    step();
    check("prio_y",  y8, 8'h00);
    check("prio_ov", {7'd0, ov8}, 8'h00);
    drive(1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    step();
    check("prio_idle_y",  y8, 8'h00);
    check("prio_idle_ov", {7'd0, ov8}, 8'h00);

    // Random traffic with occasional reset pulses; the model checks each cycle.
    for (int i = 0; i < 1000; i++) begin
      drive(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            W'($urandom), W'($urandom), W'($urandom));
      step();
    end

    drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    step();
    step();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
